// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRA/SRL/ROR sequencer driving an external 16-bit SLL/SRA barrel shifter.
// Define SHIFT_SEQ_ROR_EN to build the two-pass ROR path; otherwise ROR returns its operand with rsp_err set.
module shift_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_data,
  input  logic [3:0]  req_amt,
  input  logic [1:0]  req_op,
  output logic [15:0] sh_in,
  output logic [3:0]  sh_val,
  output logic        sh_mode,
  input  logic [15:0] sh_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  // Handshakes: a transfer happens on any rising edge where valid && ready;
  // valid may not depend on ready, and the response stays stable until taken.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PASS1 = 2'd1;
`ifdef SHIFT_SEQ_ROR_EN
  localparam logic [1:0] PASS2 = 2'd2;
`endif
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_ROR = 2'b10;

  logic [1:0]  state;
  logic [15:0] data_q;
  logic [3:0]  amt_q;
  logic [1:0]  op_q;
  logic [15:0] pass1_res;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  // SRL and ROR (op[1] set) reuse the arithmetic shift, so the sign-filled upper bits are cleared.
  assign pass1_res = op_q[1] ? (sh_out & (16'hFFFF >> amt_q)) : sh_out;

  always_comb begin
    sh_in   = 16'h0000;
    sh_val  = 4'd0;
    sh_mode = 1'b0;
    case (state)
      PASS1: begin
        sh_in   = data_q;
        sh_mode = (op_q != OP_SLL);
`ifdef SHIFT_SEQ_ROR_EN
        sh_val  = amt_q;
`else
        sh_val  = (op_q == OP_ROR) ? 4'd0 : amt_q;
`endif
      end
`ifdef SHIFT_SEQ_ROR_EN
      PASS2: begin
        // Left shift by 16-amt supplies the bits rotated out of the low end.
        sh_in   = data_q;
        sh_val  = (~amt_q) + 4'd1;
        sh_mode = 1'b0;
      end
`endif
      default: begin
        sh_in   = 16'h0000;
        sh_val  = 4'd0;
        sh_mode = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_q   <= 16'h0000;
      amt_q    <= 4'd0;
      op_q     <= 2'b00;
      rsp_data <= 16'h0000;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            data_q <= req_data;
            amt_q  <= req_amt;
            op_q   <= req_op;
            state  <= PASS1;
          end
        end
        PASS1: begin
`ifdef SHIFT_SEQ_ROR_EN
          rsp_data <= pass1_res;
          rsp_err  <= 1'b0;
          if ((op_q == OP_ROR) && (amt_q != 4'd0)) begin
            state <= PASS2;
          end else begin
            state <= RESP;
          end
`else
          if (op_q == OP_ROR) begin
            rsp_data <= data_q;
            rsp_err  <= 1'b1;
          end else begin
            rsp_data <= pass1_res;
            rsp_err  <= 1'b0;
          end
          state <= RESP;
`endif
        end
`ifdef SHIFT_SEQ_ROR_EN
        PASS2: begin
          rsp_data <= rsp_data | sh_out;
          state    <= RESP;
        end
`endif
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural model of the SLL/SRA barrel shifter.
// Expectations follow SHIFT_SEQ_ROR_EN when it is defined for the build.
module tb_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_data;
  logic [3:0]  req_amt;
  logic [1:0]  req_op;
  logic [15:0] sh_in;
  logic [3:0]  sh_val;
  logic        sh_mode;
  logic [15:0] sh_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  int passed;
  int total;

  shift_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_op    (req_op),
    .sh_in     (sh_in),
    .sh_val    (sh_val),
    .sh_mode   (sh_mode),
    .sh_out    (sh_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The core's shifter: mode 0 logical left, mode 1 arithmetic right.
  always_comb begin
    if (sh_mode) sh_out = 16'($signed(sh_in) >>> sh_val);
    else         sh_out = sh_in << sh_val;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, check PASS1/PASS2 shifter drive, latency and response, then consume it.
  task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] a,
                        input logic [1:0] op, input logic [15:0] exp_d, input logic exp_err,
                        input int exp_lat, input logic [3:0] exp_v1, input logic exp_m1);
    int lat;
    lat = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_data  = d;
    req_amt   = a;
    req_op    = op;
    #1;
    check({tag, ".req_ready"}, 16'(req_ready), 16'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_data  = 16'($urandom_range(0, 65535));
    req_amt   = 4'($urandom_range(0, 15));
    @(negedge clk);
    check({tag, ".p1_in"}, sh_in, d);
    check({tag, ".p1_val"}, 16'(sh_val), 16'(exp_v1));
    check({tag, ".p1_mode"}, 16'(sh_mode), 16'(exp_m1));
    check({tag, ".p1_busy"}, {busy, rsp_valid}, 16'b10);
    for (int i = 2; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 2 && exp_lat == 3) begin
        check({tag, ".p2_val"}, 16'(sh_val), 16'(4'(5'd16 - 5'(a))));
        check({tag, ".p2_mode"}, 16'(sh_mode), 16'h0);
      end
      if (rsp_valid) lat = i;
    end
    check({tag, ".latency"}, 16'(lat), 16'(exp_lat));
    check({tag, ".rsp_data"}, rsp_data, exp_d);
    check({tag, ".rsp_err"}, 16'(rsp_err), 16'(exp_err));
    check({tag, ".resp_sh"}, sh_in | 16'(sh_val), 16'h0);
    @(posedge clk);
    #1;
    check({tag, ".after"}, {req_ready, rsp_valid, busy}, 16'b100);
  endtask

  logic saw_rsp;

  initial begin
    passed    = 0;
    total     = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_data  = 16'h0;
    req_amt   = 4'd0;
    req_op    = 2'b00;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.flags", {req_ready, rsp_valid, rsp_err, busy, sh_mode}, 16'b10000);
    check("reset.rsp_data", rsp_data, 16'h0);
    check("reset.sh", sh_in | 16'(sh_val), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle.ready", {req_ready, busy}, 16'b10);

    run_op("sll_1_4",     16'h0001, 4'd4,  2'b00, 16'h0010, 1'b0, 2, 4'd4,  1'b0);
    run_op("sra_8000_15", 16'h8000, 4'd15, 2'b01, 16'hFFFF, 1'b0, 2, 4'd15, 1'b1);
    run_op("srl_8000_15", 16'h8000, 4'd15, 2'b11, 16'h0001, 1'b0, 2, 4'd15, 1'b1);
    run_op("sll_abcd_15", 16'hABCD, 4'd15, 2'b00, 16'h8000, 1'b0, 2, 4'd15, 1'b0);
    run_op("sra_4000_14", 16'h4000, 4'd14, 2'b01, 16'h0001, 1'b0, 2, 4'd14, 1'b1);
    run_op("sll_f00d_0",  16'hF00D, 4'd0,  2'b00, 16'hF00D, 1'b0, 2, 4'd0,  1'b0);
    run_op("srl_8421_0",  16'h8421, 4'd0,  2'b11, 16'h8421, 1'b0, 2, 4'd0,  1'b1);
`ifdef SHIFT_SEQ_ROR_EN
    run_op("ror_1234_4",  16'h1234, 4'd4,  2'b10, 16'h4123, 1'b0, 3, 4'd4,  1'b1);
    run_op("ror_8001_1",  16'h8001, 4'd1,  2'b10, 16'hC000, 1'b0, 3, 4'd1,  1'b1);
    run_op("ror_1234_0",  16'h1234, 4'd0,  2'b10, 16'h1234, 1'b0, 2, 4'd0,  1'b1);
`else
    run_op("ror_1234_4",  16'h1234, 4'd4,  2'b10, 16'h1234, 1'b1, 2, 4'd0,  1'b1);
    run_op("ror_1234_0",  16'h1234, 4'd0,  2'b10, 16'h1234, 1'b1, 2, 4'd0,  1'b1);
    run_op("sll_after_ror", 16'h0003, 4'd2, 2'b00, 16'h000C, 1'b0, 2, 4'd2, 1'b0);
`endif

    // Backpressure: response held for five cycles while a stray request is pulsed.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_data  = 16'hF0F0;
    req_amt   = 4'd4;
    req_op    = 2'b11;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        req_valid = 1'b1;
        req_data  = 16'h5555;
        req_op    = 2'b00;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      check($sformatf("bp.hold%0d.flags", i), {rsp_valid, req_ready, busy, rsp_err}, 16'b1010);
      check($sformatf("bp.hold%0d.data", i), rsp_data, 16'h0F0F);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.release", {req_ready, rsp_valid, busy}, 16'b100);
    run_op("bp.next", 16'h00FF, 4'd8, 2'b00, 16'hFF00, 1'b0, 2, 4'd8, 1'b0);

    // Reset in the middle of an ROR: no response may ever appear.
    req_valid = 1'b1;
    req_data  = 16'h1234;
    req_amt   = 4'd4;
    req_op    = 2'b10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
`ifdef SHIFT_SEQ_ROR_EN
    @(posedge clk);
    #1;
    check("rst.in_pass2", 16'(sh_val), 16'd12);
`else
    check("rst.in_pass1", {busy, rsp_valid}, 16'b10);
`endif
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst.flags", {req_ready, rsp_valid, busy, rsp_err}, 16'b1000);
    check("rst.data", rsp_data, 16'h0);
    check("rst.sh", sh_in | 16'(sh_val) | 16'(sh_mode), 16'h0);
    rst_n   = 1'b1;
    saw_rsp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw_rsp = saw_rsp | rsp_valid;
    end
    check("rst.no_rsp", 16'(saw_rsp), 16'h0);
    run_op("rst.sll", 16'h0001, 4'd4, 2'b00, 16'h0010, 1'b0, 2, 4'd4, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
